// File: rtl/cv32e40x_sleep_cg_ctrl_pkg.sv
// Shared types and helpers for the WFI sleep clock-gate sequencer.
package cv32e40x_sleep_cg_ctrl_pkg;

    typedef enum logic [1:0] {
        SLP_RUN   = 2'd0,
        SLP_DRAIN = 2'd1,
        SLP_SLEEP = 2'd2,
        SLP_WAKE  = 2'd3
    } sleep_state_e;

    // Counter width wide enough to hold the largest of the three cycle parameters.
    function automatic int unsigned sleep_cnt_width(input int unsigned a,
                                                    input int unsigned b,
                                                    input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 32'd1) ? 32'd1 : $clog2(m + 32'd1);
    endfunction

endpackage

// File: rtl/cv32e40x_sleep_cg_ctrl_if.sv
// Sleep handshake between the core controller and the sleep clock-gate sequencer.
interface cv32e40x_sleep_cg_ctrl_if;

    logic sleep_req_i;
    logic busy_i;
    logic wake_i;
    logic gate_en_o;
    logic core_sleep_o;
    logic wake_ack_o;
    logic drain_abort_o;

    modport master (
        output sleep_req_i, busy_i, wake_i,
        input  gate_en_o, core_sleep_o, wake_ack_o, drain_abort_o
    );

    modport slave (
        input  sleep_req_i, busy_i, wake_i,
        output gate_en_o, core_sleep_o, wake_ack_o, drain_abort_o
    );

endinterface

// File: rtl/cv32e40x_clock_gate.sv
// Core clock gate: enable captured while the clock is low, so the gated clock never glitches.
module cv32e40x_clock_gate (
    input  logic clk_i,
    input  logic en_i,
    input  logic scan_cg_en_i,
    output logic clk_o
);

    logic en_r;

    // Hold the enable stable across the high phase of clk_i.
    always_ff @(negedge clk_i) begin
        en_r <= en_i | scan_cg_en_i;
    end

    assign clk_o = clk_i & en_r;

endmodule

// File: rtl/cv32e40x_sleep_cg_ctrl_chk.sv
// Elaboration-time sanity checks on the sequencer parameters.
module cv32e40x_sleep_cg_ctrl_chk #(
    parameter int unsigned IDLE_CYCLES   = 2,
    parameter int unsigned WAKE_CYCLES   = 2,
    parameter int unsigned DRAIN_TIMEOUT = 64
) (
    input logic clk_i
);

    a_idle_cycles_min : assert property (@(posedge clk_i) IDLE_CYCLES >= 32'd1);
    a_wake_cycles_min : assert property (@(posedge clk_i) WAKE_CYCLES >= 32'd1);
    a_timeout_range   : assert property (@(posedge clk_i)
                            (DRAIN_TIMEOUT == 32'd0) || (DRAIN_TIMEOUT > IDLE_CYCLES));

endmodule

// File: rtl/cv32e40x_sleep_cg_ctrl.sv
// WFI sleep sequencer: drains outstanding activity, gates the core clock, restores it on wake.
module cv32e40x_sleep_cg_ctrl
    import cv32e40x_sleep_cg_ctrl_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES   = 2,
    parameter int unsigned WAKE_CYCLES   = 2,
    parameter int unsigned DRAIN_TIMEOUT = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          scan_cg_en_i,
    output logic                          clk_gated_o,
    cv32e40x_sleep_cg_ctrl_if.slave       bus
);

    localparam int unsigned CNT_W      = sleep_cnt_width(IDLE_CYCLES, WAKE_CYCLES, DRAIN_TIMEOUT);
    localparam bit          TIMEOUT_EN = (DRAIN_TIMEOUT != 32'd0);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = TIMEOUT_EN ? CNT_W'(DRAIN_TIMEOUT - 32'd1) : '0;

    sleep_state_e     state_r, state_next;
    logic [CNT_W-1:0] idle_cnt_r, idle_cnt_next;
    logic [CNT_W-1:0] drain_cnt_r, drain_cnt_next;
    logic [CNT_W-1:0] wake_cnt_r, wake_cnt_next;
    logic             wake_ack_next, drain_abort_next;
    logic             gate_en_r, core_sleep_r, wake_ack_r, drain_abort_r;

    // Next-state and counter update; wake always beats a sleep request.
    always_comb begin
        state_next       = state_r;
        idle_cnt_next    = idle_cnt_r;
        drain_cnt_next   = drain_cnt_r;
        wake_cnt_next    = wake_cnt_r;
        wake_ack_next    = 1'b0;
        drain_abort_next = 1'b0;
        case (state_r)
            SLP_RUN: begin
                if (bus.sleep_req_i && !bus.wake_i) begin
                    state_next     = SLP_DRAIN;
                    idle_cnt_next  = '0;
                    drain_cnt_next = '0;
                end else begin
                    state_next = SLP_RUN;
                end
            end
            SLP_DRAIN: begin
                if (TIMEOUT_EN) begin
                    drain_cnt_next = drain_cnt_r + CNT_W'(1);
                end else begin
                    drain_cnt_next = drain_cnt_r;
                end
                // Timeout is checked ahead of the idle terminal count so it wins a tie.
                if (bus.wake_i || !bus.sleep_req_i) begin
                    state_next = SLP_RUN;
                end else if (TIMEOUT_EN && (drain_cnt_r == DRAIN_LAST)) begin
                    state_next       = SLP_RUN;
                    drain_abort_next = 1'b1;
                end else if (bus.busy_i) begin
                    idle_cnt_next = '0;
                end else if (idle_cnt_r == IDLE_LAST) begin
                    state_next = SLP_SLEEP;
                end else begin
                    idle_cnt_next = idle_cnt_r + CNT_W'(1);
                end
            end
            SLP_SLEEP: begin
                if (bus.wake_i) begin
                    state_next    = SLP_WAKE;
                    wake_cnt_next = '0;
                end else begin
                    state_next = SLP_SLEEP;
                end
            end
            SLP_WAKE: begin
                if (wake_cnt_r == WAKE_LAST) begin
                    state_next    = SLP_RUN;
                    wake_ack_next = 1'b1;
                end else begin
                    wake_cnt_next = wake_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_next = SLP_RUN;
            end
        endcase
    end

    // State, counters and outputs all registered from next-state so they change together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r       <= SLP_RUN;
            idle_cnt_r    <= '0;
            drain_cnt_r   <= '0;
            wake_cnt_r    <= '0;
            gate_en_r     <= 1'b1;
            core_sleep_r  <= 1'b0;
            wake_ack_r    <= 1'b0;
            drain_abort_r <= 1'b0;
        end else begin
            state_r       <= state_next;
            idle_cnt_r    <= idle_cnt_next;
            drain_cnt_r   <= drain_cnt_next;
            wake_cnt_r    <= wake_cnt_next;
            gate_en_r     <= (state_next != SLP_SLEEP);
            core_sleep_r  <= (state_next == SLP_SLEEP);
            wake_ack_r    <= wake_ack_next;
            drain_abort_r <= drain_abort_next;
        end
    end

    assign bus.gate_en_o     = gate_en_r;
    assign bus.core_sleep_o  = core_sleep_r;
    assign bus.wake_ack_o    = wake_ack_r;
    assign bus.drain_abort_o = drain_abort_r;

    cv32e40x_clock_gate core_cg_i (
        .clk_i        (clk_i),
        .en_i         (gate_en_r),
        .scan_cg_en_i (scan_cg_en_i),
        .clk_o        (clk_gated_o)
    );

`ifndef SYNTHESIS
    cv32e40x_sleep_cg_ctrl_chk #(
        .IDLE_CYCLES   (IDLE_CYCLES),
        .WAKE_CYCLES   (WAKE_CYCLES),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
    ) param_chk_i (
        .clk_i (clk_i)
    );
`endif

endmodule

// File: tb/tb_cv32e40x_sleep_cg_ctrl.sv
// Scoreboard bench for the sleep sequencer: each row drives one cycle of stimulus and
// queues the outputs expected right after the following clock edge.
module tb_cv32e40x_sleep_cg_ctrl;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic scan_cg_en_i = 1'b0;
    logic clk_gated_o;

    cv32e40x_sleep_cg_ctrl_if sif ();

    cv32e40x_sleep_cg_ctrl #(
        .IDLE_CYCLES   (2),
        .WAKE_CYCLES   (2),
        .DRAIN_TIMEOUT (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .scan_cg_en_i (scan_cg_en_i),
        .clk_gated_o  (clk_gated_o),
        .bus          (sif.slave)
    );

    always #5 clk_i = ~clk_i;

    // Stimulus row: {rst, sleep_req, busy, wake, scan}
    // Expected row: {gate_en, core_sleep, wake_ack, drain_abort, clk_gated sampled in high phase}
    logic [4:0] exp_q [$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic apply(input logic [4:0] s, input logic [4:0] e);
        rst_i           = s[4];
        sif.sleep_req_i = s[3];
        sif.busy_i      = s[2];
        sif.wake_i      = s[1];
        scan_cg_en_i    = s[0];
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [4:0] observe();
        return {sif.gate_en_o, sif.core_sleep_o, sif.wake_ack_o, sif.drain_abort_o, clk_gated_o};
    endfunction

    task automatic test_reset();
        logic [4:0] st [2];
        logic [4:0] ex [2];
        logic [4:0] e;
        logic [4:0] o;
        st = '{5'b10000, 5'b00000};
        ex = '{5'b10001, 5'b10001};
        rst_i = 1'b1;
        sif.sleep_req_i = 1'b0;
        sif.busy_i = 1'b0;
        sif.wake_i = 1'b0;
        scan_cg_en_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        for (int i = 0; i < 2; i++) begin
            apply(st[i], ex[i]);
            o = observe();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_sleep_entry();
        logic [4:0] st [5];
        logic [4:0] ex [5];
        logic [4:0] e;
        logic [4:0] o;
        st = '{5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b00000};
        ex = '{5'b10001, 5'b10001, 5'b01001, 5'b01000, 5'b01000};
        for (int i = 0; i < 5; i++) begin
            apply(st[i], ex[i]);
            o = observe();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sleep_entry[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_wake();
        logic [4:0] st [4];
        logic [4:0] ex [4];
        logic [4:0] e;
        logic [4:0] o;
        st = '{5'b00010, 5'b00000, 5'b00000, 5'b00000};
        ex = '{5'b10000, 5'b10001, 5'b10101, 5'b10001};
        for (int i = 0; i < 4; i++) begin
            apply(st[i], ex[i]);
            o = observe();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wake[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_busy_toggle();
        logic [4:0] st [10];
        logic [4:0] ex [10];
        logic [4:0] e;
        logic [4:0] o;
        st = '{5'b01100, 5'b01100, 5'b01000, 5'b01100, 5'b01000,
               5'b01000, 5'b00010, 5'b00000, 5'b00000, 5'b00000};
        ex = '{5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001,
               5'b01001, 5'b10000, 5'b10001, 5'b10101, 5'b10001};
        for (int i = 0; i < 10; i++) begin
            apply(st[i], ex[i]);
            o = observe();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL busy_toggle[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_timeout();
        logic [4:0] st [11];
        logic [4:0] ex [11];
        logic [4:0] e;
        logic [4:0] o;
        st = '{5'b01100, 5'b01100, 5'b01100, 5'b01100, 5'b01100, 5'b01100,
               5'b01100, 5'b01100, 5'b01100, 5'b00100, 5'b00000};
        ex = '{5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001,
               5'b10001, 5'b10001, 5'b10011, 5'b10001, 5'b10001};
        for (int i = 0; i < 11; i++) begin
            apply(st[i], ex[i]);
            o = observe();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL timeout[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_priority();
        logic [4:0] st [8];
        logic [4:0] ex [8];
        logic [4:0] e;
        logic [4:0] o;
        st = '{5'b01010, 5'b01010, 5'b01000, 5'b01010,
               5'b01000, 5'b01000, 5'b01000, 5'b01000};
        ex = '{5'b10001, 5'b10001, 5'b10001, 5'b10001,
               5'b10001, 5'b10001, 5'b01001, 5'b01000};
        for (int i = 0; i < 8; i++) begin
            apply(st[i], ex[i]);
            o = observe();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL priority[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_reset_in_sleep();
        logic [4:0] st [6];
        logic [4:0] ex [6];
        logic [4:0] e;
        logic [4:0] o;
        st = '{5'b00001, 5'b00001, 5'b00000, 5'b10000, 5'b00000, 5'b00000};
        ex = '{5'b01001, 5'b01001, 5'b01000, 5'b10000, 5'b10001, 5'b10001};
        for (int i = 0; i < 6; i++) begin
            apply(st[i], ex[i]);
            o = observe();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_in_sleep[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] st [13];
        logic [4:0] ex [13];
        logic [4:0] e;
        logic [4:0] o;
        st = '{5'b01000, 5'b01000, 5'b01000, 5'b01010, 5'b01010, 5'b01000, 5'b01000,
               5'b01000, 5'b01000, 5'b00010, 5'b00000, 5'b00000, 5'b00000};
        ex = '{5'b10001, 5'b10001, 5'b01001, 5'b10000, 5'b10001, 5'b10101, 5'b10001,
               5'b10001, 5'b01001, 5'b10000, 5'b10001, 5'b10101, 5'b10001};
        for (int i = 0; i < 13; i++) begin
            apply(st[i], ex[i]);
            o = observe();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sleep_entry();
        test_wake();
        test_busy_toggle();
        test_timeout();
        test_priority();
        test_reset_in_sleep();
        test_back_to_back();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
